// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fpu_pkg
// Brief    : Shared FPU result-path types: flag bit indices and the
//            writeback entry layout.
// Revision : 1.0 - initial release
// ============================================================================
package fpu_pkg;

    localparam int RD_W = 5;
    localparam int DW   = 32;
    localparam int FW   = 5;

    // Bit positions follow the fflags CSR layout.
    localparam int FLAG_NX = 0;
    localparam int FLAG_UF = 1;
    localparam int FLAG_OF = 2;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_NV = 4;

    typedef struct packed {
        logic [RD_W-1:0] rd;
        logic [DW-1:0]   data;
        logic [FW-1:0]   flags;
    } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/fpu_wb_queue_cam.sv
`default_nettype none
// ============================================================================
// Module   : fpu_wb_queue_cam
// Brief    : Destination-register match across a set of tracked entries.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_wb_queue_cam
    import fpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0]           i_valid,
    input  logic [DEPTH-1:0][RD_W-1:0] i_rd,
    input  logic [RD_W-1:0]            i_chk_rd,
    output logic                       o_hit
);

    logic [DEPTH-1:0] w_match;

    for (genvar g = 0; g < DEPTH; g++) begin : g_match
        assign w_match[g] = i_valid[g] && (i_rd[g] == i_chk_rd);
    end

    assign o_hit = |w_match;

endmodule
`default_nettype wire

// File: rtl/fpu_wb_queue.sv
`default_nettype none
// ============================================================================
// Module   : fpu_wb_queue
// Brief    : In-order FPU result queue feeding the FP register-file write
//            port, with pending-rd hazard lookup and sticky flag accumulation.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_wb_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int FW    = 5
) (
    input  logic                     clk,
    input  logic                     clrn,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic [4:0]               push_rd,
    input  logic [DW-1:0]            push_data,
    input  logic [FW-1:0]            push_flags,
    output logic                     pop_valid,
    input  logic                     pop_ready,
    output logic [4:0]               pop_rd,
    output logic [DW-1:0]            pop_data,
    output logic [FW-1:0]            pop_flags,
    input  logic                     flush,
    input  logic [4:0]               chk_rd,
    output logic                     chk_hit,
    output logic [$clog2(DEPTH):0]   count,
    output logic [FW-1:0]            fflags_acc,
    input  logic                     acc_clr
);
    import fpu_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]              r_wr_ptr;
    logic [AW-1:0]              r_rd_ptr;
    logic [CW-1:0]              r_count;
    logic [FW-1:0]              r_fflags_acc;
    logic [DEPTH-1:0]           r_valid;
    logic [DEPTH-1:0][RD_W-1:0] r_rd;
    logic [DW-1:0]              r_data  [DEPTH];
    logic [FW-1:0]              r_flags [DEPTH];

    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_full     = (r_count == CW'(DEPTH));
    assign push_ready = !w_full && !flush;
    assign pop_valid  = r_valid[r_rd_ptr];
    assign w_push     = push_valid && push_ready;
    assign w_pop      = pop_valid && pop_ready;

    // Head is masked to zero when empty so writeback never sees stale data.
    assign pop_rd    = pop_valid ? r_rd[r_rd_ptr]    : '0;
    assign pop_data  = pop_valid ? r_data[r_rd_ptr]  : '0;
    assign pop_flags = pop_valid ? r_flags[r_rd_ptr] : '0;

    assign count      = r_count;
    assign fflags_acc = r_fflags_acc;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
            r_rd     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i]  <= '0;
                r_flags[i] <= '0;
            end
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
        end else begin
            if (w_push) begin
                r_valid[r_wr_ptr] <= 1'b1;
                r_rd[r_wr_ptr]    <= push_rd;
                r_data[r_wr_ptr]  <= push_data;
                r_flags[r_wr_ptr] <= push_flags;
                r_wr_ptr          <= r_wr_ptr + AW'(1);
            end
            // Push and pop never target the same slot: that needs empty or full.
            if (w_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A pop retiring alongside a flush still counts toward the sticky flags.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_fflags_acc <= '0;
        end else if (acc_clr) begin
            r_fflags_acc <= w_pop ? pop_flags : '0;
        end else if (w_pop) begin
            r_fflags_acc <= r_fflags_acc | pop_flags;
        end
    end

    fpu_wb_queue_cam #(
        .DEPTH (DEPTH)
    ) u_cam (
        .i_valid  (r_valid),
        .i_rd     (r_rd),
        .i_chk_rd (chk_rd),
        .o_hit    (chk_hit)
    );

    a_hold_payload : assert property (
        @(posedge clk) disable iff (!clrn)
        (push_valid && !push_ready && !flush) |=> $stable({push_rd, push_data, push_flags})
    ) else $error("push payload changed while stalled");

endmodule
`default_nettype wire

// File: tb/tb_fpu_wb_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_wb_queue
// Brief    : Directed self-checking bench for fpu_wb_queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_wb_queue;
    import fpu_pkg::*;

    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          clrn;
    logic          push_valid;
    logic          push_ready;
    logic [4:0]    push_rd;
    logic [DW-1:0] push_data;
    logic [FW-1:0] push_flags;
    logic          pop_valid;
    logic          pop_ready;
    logic [4:0]    pop_rd;
    logic [DW-1:0] pop_data;
    logic [FW-1:0] pop_flags;
    logic          flush;
    logic [4:0]    chk_rd;
    logic          chk_hit;
    logic [2:0]    count;
    logic [FW-1:0] fflags_acc;
    logic          acc_clr;

    int checks = 0;
    int errors = 0;

    localparam logic [FW-1:0] C_NX = 5'(1 << FLAG_NX);
    localparam logic [FW-1:0] C_OF = 5'(1 << FLAG_OF);
    localparam logic [FW-1:0] C_NV = 5'(1 << FLAG_NV);

    fpu_wb_queue #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .FW    (FW)
    ) dut (
        .clk        (clk),
        .clrn       (clrn),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_rd    (push_rd),
        .push_data  (push_data),
        .push_flags (push_flags),
        .pop_valid  (pop_valid),
        .pop_ready  (pop_ready),
        .pop_rd     (pop_rd),
        .pop_data   (pop_data),
        .pop_flags  (pop_flags),
        .flush      (flush),
        .chk_rd     (chk_rd),
        .chk_hit    (chk_hit),
        .count      (count),
        .fflags_acc (fflags_acc),
        .acc_clr    (acc_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [4:0] rd, input logic [DW-1:0] data,
                            input logic [FW-1:0] flags);
        push_valid = 1'b1;
        push_rd    = rd;
        push_data  = data;
        push_flags = flags;
        tick();
        push_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        clrn       = 1'b0;
        push_valid = 1'b0;
        push_rd    = '0;
        push_data  = '0;
        push_flags = '0;
        pop_ready  = 1'b0;
        flush      = 1'b0;
        chk_rd     = '0;
        acc_clr    = 1'b0;

        repeat (3) @(posedge clk);
        #1 clrn = 1'b1;
        #1;
        chk("rst_count", count, 0);
        chk("rst_pop_valid", pop_valid, 0);
        chk("rst_push_ready", push_ready, 1);
        chk("rst_fflags", fflags_acc, 0);
        chk("rst_pop_data", pop_data, 0);
        chk("rst_chk_hit", chk_hit, 0);

        // Fill to DEPTH with the reader stalled.
        for (int i = 1; i <= 4; i++) push_one(5'(i), 32'h3F80_0000 + i, '0);
        push_valid = 1'b1;
        push_rd    = 5'd5;
        push_data  = 32'h3F80_0005;
        #1;
        chk("full_count", count, 4);
        chk("full_push_ready", push_ready, 0);
        chk("full_head", pop_data, 32'h3F80_0001);
        tick();
        push_valid = 1'b0;
        #1 chk("full_reject_count", count, 4);

        pop_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain_data", pop_data, 32'h3F80_0000 + i);
            chk("drain_rd", pop_rd, i);
            tick();
        end
        pop_ready = 1'b0;
        #1;
        chk("drain_count", count, 0);
        chk("drain_pop_valid", pop_valid, 0);
        chk("drain_masked", pop_data, 0);

        // Steady push+pop at count 2 wraps both pointers.
        push_one(5'd1, 32'h100, '0);
        push_one(5'd2, 32'h101, '0);
        push_valid = 1'b1;
        pop_ready  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            push_rd   = 5'(k);
            push_data = 32'h102 + k;
            #1;
            chk("ss_count", count, 2);
            chk("ss_data", pop_data, 32'h100 + k);
            tick();
        end
        push_valid = 1'b0;
        for (int k = 10; k < 12; k++) begin
            chk("ss_tail", pop_data, 32'h100 + k);
            tick();
        end
        pop_ready = 1'b0;
        #1 chk("ss_empty", count, 0);

        // Sticky flag accumulation and clear-then-OR.
        push_one(5'd1, 32'h1, C_NX);
        push_one(5'd2, 32'h2, C_NV);
        push_one(5'd3, 32'h3, C_OF);
        pop_ready = 1'b1;
        tick();
        chk("acc_nx", fflags_acc, 5'h01);
        tick();
        chk("acc_nx_nv", fflags_acc, 5'h11);
        acc_clr = 1'b1;
        tick();
        acc_clr   = 1'b0;
        pop_ready = 1'b0;
        chk("acc_clr_pop", fflags_acc, 5'h04);
        chk("acc_empty", count, 0);
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        chk("acc_clr_only", fflags_acc, 0);

        // Flush with a concurrent head pop and offered push.
        push_one(5'd7, 32'hA0, 5'h02);
        push_one(5'd8, 32'hA1, 5'h08);
        push_one(5'd9, 32'hA2, 5'h01);
        #1 chk("fl_pre_count", count, 3);
        flush      = 1'b1;
        pop_ready  = 1'b1;
        push_valid = 1'b1;
        push_rd    = 5'd20;
        push_data  = 32'hDEAD;
        push_flags = 5'h10;
        #1;
        chk("fl_push_ready", push_ready, 0);
        chk("fl_head", pop_data, 32'hA0);
        tick();
        flush      = 1'b0;
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        chk_rd     = 5'd20;
        #1;
        chk("fl_count", count, 0);
        chk("fl_pop_valid", pop_valid, 0);
        chk("fl_fflags", fflags_acc, 5'h02);
        chk("fl_no_store", chk_hit, 0);
        tick();
        chk("fl_still_empty", pop_valid, 0);

        // Pending-rd hazard lookup.
        push_one(5'd5, 32'h55, '0);
        push_one(5'd9, 32'h99, '0);
        chk_rd = 5'd9;
        #1 chk("hz_hit9", chk_hit, 1);
        chk_rd = 5'd6;
        #1 chk("hz_miss6", chk_hit, 0);
        chk_rd    = 5'd9;
        pop_ready = 1'b1;
        tick();
        chk("hz_hit9_after5", chk_hit, 1);
        tick();
        pop_ready = 1'b0;
        chk("hz_miss9_popped", chk_hit, 0);
        chk_rd = 5'd0;
        #1 chk("hz_empty_f0", chk_hit, 0);
        push_valid = 1'b1;
        push_rd    = 5'd0;
        push_data  = 32'hF0;
        push_flags = '0;
        #1 chk("hz_push_excluded", chk_hit, 0);
        tick();
        push_valid = 1'b0;
        chk("hz_f0_hit", chk_hit, 1);
        pop_ready = 1'b1;
        tick();
        pop_ready = 1'b0;

        // Asynchronous reset mid-cycle with entries held.
        push_one(5'd1, 32'h11, '0);
        push_one(5'd2, 32'h22, '0);
        push_one(5'd3, 32'h33, '0);
        #1 chk("ar_pre_count", count, 3);
        #2 clrn = 1'b0;
        #1;
        chk("ar_count", count, 0);
        chk("ar_pop_valid", pop_valid, 0);
        chk("ar_push_ready", push_ready, 1);
        chk("ar_pop_data", pop_data, 0);
        chk("ar_fflags", fflags_acc, 0);
        tick();
        clrn = 1'b1;
        #1 chk("ar_release_count", count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fpu_wb_queue.md
Name: fpu_wb_queue

Overview:
- In-order result queue between the pipelined FPU and the FP register-file write port.
- The FPU pushes completed results {rd, data, flags}. Writeback pops them whenever the write port is free.
- It is the draining end of the FPU result path: it also provides a pending-rd hazard check for ID-stage stall logic and is flushed when an interrupt is taken.
- Head register contents are presented first-word-fall-through to writeback.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- DW, 32, result data width.
- FW, 5, exception-flag width (NV, DZ, OF, UF, NX).

Ports:
- clk  in  1  rising-edge clock.
- clrn  in  1  asynchronous active-low reset.
- push_valid  in  1  FPU has a result this cycle.
- push_ready  out  1  queue accepts a push this cycle.
- push_rd  in  5  destination FP register.
- push_data  in  DW  result value.
- push_flags  in  FW  exception flags of the result.
- pop_valid  out  1  head entry is valid.
- pop_ready  in  1  writeback consumes the head this cycle.
- pop_rd  out  5  head destination register.
- pop_data  out  DW  head result value.
- pop_flags  out  FW  head exception flags.
- flush  in  1  interrupt or exception taken; discard all entries.
- chk_rd  in  5  source register queried by ID stage.
- chk_hit  out  1  some valid entry targets chk_rd.
- count  out  $clog2(DEPTH)+1  number of valid entries.
- fflags_acc  out  FW  sticky OR of flags of all popped entries.
- acc_clr  in  1  clear fflags_acc (CSR write to fflags).

Behaviour:
- Single clock domain (clk). Reset is asynchronous and active-low (clrn). All state updates on posedge clk; clrn low forces reset immediately, independent of clk.
- Reset values:
  - wr_ptr = rd_ptr = 0, count = 0, fflags_acc = 0, all storage entries and valid bits 0.
  - Outputs: pop_valid = 0, pop_rd = 0, pop_data = 0, pop_flags = 0, chk_hit = 0, push_ready = 1.
- Storage: DEPTH x {rd, data, flags, valid} registers. Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count carries an extra bit so DEPTH is representable.
- push_ready = (count != DEPTH) && !flush.
  - Full: push_ready = 0 even if a pop occurs the same cycle; no full-bypass.
- A push is accepted when push_valid && push_ready: entry[wr_ptr] is written and marked valid, wr_ptr increments.
- A pop occurs when pop_valid && pop_ready: entry[rd_ptr] valid bit is cleared, rd_ptr increments, and fflags_acc |= pop_flags.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged; both pointers advance.
- Empty: pop_valid = 0 and pop_rd/pop_data/pop_flags = 0 (masked).
  - Push-to-pop latency is 1 cycle: a result pushed at edge N is visible on pop_* after edge N.
  - No combinational push-to-pop bypass.
- pop_* are driven from entry[rd_ptr] and remain stable while pop_valid && !pop_ready.
- flush, at the next edge:
  - All valid bits cleared; count = 0; wr_ptr = rd_ptr = 0.
  - A push presented in the same cycle is rejected (push_ready = 0).
  - A pop handshake in the same cycle still ORs its flags into fflags_acc (that instruction retired); all other entries are discarded without flag update.
- fflags_acc: acc_clr clears it. If acc_clr and a pop coincide, the result is exactly the popped flags (clear first, then OR). fflags_acc is not affected by flush.
- chk_hit: combinational OR over all entries of (valid && rd == chk_rd).
  - Includes the head even if it is popping this cycle; the conservative stall is intended.
  - Excludes a push arriving this cycle.
- rd = 0 is a legal FP register (f0) and gets no special treatment.
- A push attempted when full is dropped, and the FPU must hold it. An assertion flags push_valid && !push_ready && a changing payload.

Decomposition:
- Package fpu_pkg:
  - FLAG_NV/DZ/OF/UF/NX bit indices and FW.
  - A wb_entry_t struct {rd[4:0], data[DW-1:0], flags[FW-1:0]}.
- Sub-module: fpu_wb_queue_cam. Parameterized DEPTH; takes the valid vector and the rd array, produces chk_hit. It is reused for the pending-load scoreboard.
- Pointer/count logic stays in the top module.

Test Plan:
- Reset then idle:
  - Hold clrn = 0 for 3 cycles, then release -> count = 0, pop_valid = 0, push_ready = 1, fflags_acc = 0.
  - Assert clrn low mid-cycle while count = 3 -> outputs return to reset values immediately, before the next clk.
- Fill and drain:
  - 4 pushes (rd = 1..4, data = 0x3F800000 + i, flags = 0) with pop_ready = 0 -> count = 4, push_ready = 0, a fifth push is rejected.
  - Then pop_ready = 1 -> data pops in order 1..4 on consecutive cycles; count reaches 0; pop_valid drops.
- Simultaneous push/pop at count = 2 for 10 cycles -> count stays 2, pointers wrap past 3->0, pop order equals push order.
- Flag accumulation:
  - Pop entries with flags 0x01, then 0x10 -> fflags_acc = 0x11.
  - acc_clr together with a pop of flags 0x04 -> fflags_acc = 0x04.
- Flush with count = 3 while a push is offered and the head pops:
  - Next cycle count = 0, pop_valid = 0, and the offered push is not stored.
  - fflags_acc includes only the popped head's flags.
- Hazard check: queue holds rd {5, 9} ->
  - chk_rd = 9 gives chk_hit = 1.
  - chk_rd = 6 gives 0.
  - After rd 9 pops, chk_rd = 9 gives 0.
  - With the queue empty, chk_rd = 0 gives 0.
